// File: rtl/buzzer_note_pkg.sv
// Shared definitions for the buzzer note player: note table, pitch helper,
// FSM state encoding and LED codes.
package buzzer_note_pkg;

    typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;

    localparam logic [2:0] LED_OFF  = 3'b111;
    localparam logic [2:0] LED_TONE = 3'b110;
    localparam logic [2:0] LED_REST = 3'b101;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_C5   = 4'd13;

    // C4..C5 chromatic, indexed by code-1
    localparam int FREQ_HZ [13] = '{262, 277, 294, 311, 330, 349, 370,
                                    392, 415, 440, 466, 494, 523};

    function automatic logic is_pitched(input logic [3:0] code);
        return (code >= NOTE_C4) && (code <= NOTE_C5);
    endfunction

    // Half-period in clock cycles; non-pitched codes return 1 so the
    // entry is still a legal counter limit.
    function automatic int half_period(input int clk_hz, input int code);
        int h;
        if (code < 1 || code > 13) return 1;
        h = clk_hz / (2 * FREQ_HZ[code-1]);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_HZ/1000 cycles after clr.
module ms_tick_gen #(
    parameter int CLK_HZ = 24000000
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic clr,
    output logic tick
);
    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int PW     = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

    logic [PW-1:0] cnt;

    assign tick = (cnt == PW'(MS_CYC - 1)) && !clr;

    always_ff @(posedge CLK_IN) begin
        if (!RST_N || clr || tick) cnt <= '0;
        else                       cnt <= cnt + PW'(1);
    end
endmodule

// File: rtl/buzzer_note_player.sv
// Plays one note request at a time as a square wave on BZ for the requested
// duration, then holds a fixed silent gap before accepting the next one.
module buzzer_note_player
    import buzzer_note_pkg::*;
#(
    parameter int CLK_HZ = 24000000,
    parameter int GAP_MS = 20
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       NOTE_VALID,
    output logic       NOTE_READY,
    input  logic [3:0] NOTE_CODE,
    input  logic [9:0] NOTE_DUR_MS,
    output logic       BZ,
    output logic [2:0] RGB_LED,
    output logic       BUSY
);
    localparam int         HW       = $clog2(half_period(CLK_HZ, 1) + 1);
    localparam logic [9:0] GAP_LAST = 10'(GAP_MS - 1);
    localparam bit         HAS_GAP  = (GAP_MS != 0);

    state_t          state, state_n;
    logic [3:0]      code_q, code_n;
    logic [9:0]      dur_q, dur_n, ms_cnt, ms_n;
    logic [HW-1:0]   hcnt, h_n;
    logic            bz_n;
    logic [2:0]      led_n;
    logic            tick;
    logic [HW-1:0]   half_tbl [16];

    // Constant-argument calls fold to a small ROM; no runtime divider.
    for (genvar i = 0; i < 16; i++) begin : g_half
        assign half_tbl[i] = HW'(half_period(CLK_HZ, i));
    end

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .clr    (state == S_IDLE),
        .tick   (tick)
    );

    assign NOTE_READY = (state == S_IDLE);
    assign BUSY       = (state != S_IDLE);

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            code_q  <= '0;
            dur_q   <= '0;
            ms_cnt  <= '0;
            hcnt    <= '0;
            BZ      <= 1'b0;
            RGB_LED <= LED_OFF;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            dur_q   <= dur_n;
            ms_cnt  <= ms_n;
            hcnt    <= h_n;
            BZ      <= bz_n;
            RGB_LED <= led_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code_q;
        dur_n   = dur_q;
        ms_n    = ms_cnt;
        h_n     = hcnt;
        bz_n    = BZ;
        led_n   = RGB_LED;
        case (state)
            S_IDLE: begin
                if (NOTE_VALID) begin
                    code_n = NOTE_CODE;
                    dur_n  = NOTE_DUR_MS;
                    ms_n   = '0;
                    h_n    = '0;
                    bz_n   = 1'b0;
                    // zero-length requests are consumed without playing
                    if (NOTE_DUR_MS != 10'd0) begin
                        state_n = S_TONE;
                        led_n   = is_pitched(NOTE_CODE) ? LED_TONE : LED_REST;
                    end
                end
            end
            S_TONE: begin
                if (is_pitched(code_q)) begin
                    if (hcnt == half_tbl[code_q] - HW'(1)) begin
                        h_n  = '0;
                        bz_n = ~BZ;
                    end else begin
                        h_n  = hcnt + HW'(1);
                    end
                end
                if (tick) begin
                    if (ms_cnt == dur_q - 10'd1) begin
                        ms_n    = '0;
                        h_n     = '0;
                        bz_n    = 1'b0;
                        led_n   = LED_OFF;
                        state_n = HAS_GAP ? S_GAP : S_IDLE;
                    end else begin
                        ms_n = ms_cnt + 10'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (ms_cnt == GAP_LAST) begin
                        ms_n    = '0;
                        state_n = S_IDLE;
                    end else begin
                        ms_n = ms_cnt + 10'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                bz_n    = 1'b0;
                led_n   = LED_OFF;
            end
        endcase
    end
endmodule

// File: tb/tb_buzzer_note_player.sv
// Directed and randomized checks of buzzer_note_player against a cycle-level
// waveform model derived from note frequency, duration and gap length.
module tb_buzzer_note_player;
    localparam int CLK_HZ = 100000;
    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int GAP_A  = 2;
    localparam int GAP_B  = 0;
    localparam int FREQ [13] = '{262, 277, 294, 311, 330, 349, 370,
                                 392, 415, 440, 466, 494, 523};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld, sel;
    logic [3:0] code;
    logic [9:0] dur;
    logic       rdy_a, bz_a, busy_a, rdy_b, bz_b, busy_b;
    logic [2:0] led_a, led_b;
    logic       o_rdy, o_bz, o_busy;
    logic [2:0] o_led;

    int    nchk = 0;
    int    nfail = 0;
    time   hs_time;

    always #5 clk = ~clk;

    buzzer_note_player #(.CLK_HZ(CLK_HZ), .GAP_MS(GAP_A)) u_dut (
        .CLK_IN(clk), .RST_N(rst_n), .NOTE_VALID(vld & ~sel), .NOTE_READY(rdy_a),
        .NOTE_CODE(code), .NOTE_DUR_MS(dur), .BZ(bz_a), .RGB_LED(led_a), .BUSY(busy_a));

    buzzer_note_player #(.CLK_HZ(CLK_HZ), .GAP_MS(GAP_B)) u_dut_nogap (
        .CLK_IN(clk), .RST_N(rst_n), .NOTE_VALID(vld & sel), .NOTE_READY(rdy_b),
        .NOTE_CODE(code), .NOTE_DUR_MS(dur), .BZ(bz_b), .RGB_LED(led_b), .BUSY(busy_b));

    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_bz   = sel ? bz_b   : bz_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_led  = sel ? led_b  : led_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_half(input int c);
        int h;
        if (c < 1 || c > 13) return 0;
        h = CLK_HZ / (2 * FREQ[c-1]);
        return (h < 1) ? 1 : h;
    endfunction

    // {BZ, RGB_LED, NOTE_READY, BUSY} expected t cycles after TONE entry
    function automatic logic [5:0] model_at(input int c, input int d, input int g, input int t);
        int h, tl, gl;
        h  = model_half(c);
        tl = d * MS_CYC;
        gl = g * MS_CYC;
        if (t < tl) begin
            if (h > 0) return {1'((t / h) % 2), 3'b110, 1'b0, 1'b1};
            return {1'b0, 3'b101, 1'b0, 1'b1};
        end
        if (t < tl + gl) return {1'b0, 3'b111, 1'b0, 1'b1};
        return {1'b0, 3'b111, 1'b1, 1'b0};
    endfunction

    // Called at a negedge. keep: leave NOTE_VALID high and present next_code
    // for a back-to-back accept. rst_at >= 0 pulses reset at that cycle.
    task automatic play(input logic [3:0] c, input logic [9:0] d, input bit keep,
                        input logic [3:0] next_code, input int rst_at, input string tag);
        int g, total, t, bad;
        logic [5:0] o, e, fo, fe;
        int ft;
        g = sel ? GAP_B : GAP_A;
        total = int'(d) * MS_CYC + g * MS_CYC;
        vld = 1'b1; code = c; dur = d;
        t = 0;
        while (!o_rdy && t < 5000) begin @(negedge clk); t++; end
        chk({tag, " ready before accept"}, 32'(o_rdy), 32'd1);
        @(posedge clk);
        hs_time = $time;
        @(negedge clk);
        if (keep) begin code = next_code; dur = 10'd1; end
        else vld = 1'b0;
        bad = 0; ft = -1; fo = '0; fe = '0;
        for (t = 0; t <= total; t++) begin
            o = {o_bz, o_led, o_rdy, o_busy};
            e = model_at(int'(c), int'(d), g, t);
            if (o !== e) begin
                if (bad == 0) begin ft = t; fo = o; fe = e; end
                bad++;
            end
            if (t == rst_at) begin
                chk({tag, " bz high before reset"}, 32'(o_bz), 32'd1);
                vld = 1'b0; rst_n = 1'b0;
                @(negedge clk);
                chk({tag, " bz after reset"},    32'(o_bz),   32'd0);
                chk({tag, " led after reset"},   32'(o_led),  32'h7);
                chk({tag, " ready after reset"}, 32'(o_rdy),  32'd1);
                chk({tag, " busy after reset"},  32'(o_busy), 32'd0);
                rst_n = 1'b1;
                break;
            end
            if (!keep && t < total) begin
                vld = 1'($urandom); code = 4'($urandom); dur = 10'($urandom);
            end
            if (!keep && t == total) vld = 1'b0;
            if (t < total) @(negedge clk);
        end
        nchk++;
        assert (bad === 0) else begin
            nfail++;
            $error("FAIL %s waveform: %0d bad cycles, first at t=%0d got %b expected %b",
                   tag, bad, ft, fo, fe);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        time t1;
        rst_n = 1'b0; vld = 1'b0; sel = 1'b0; code = '0; dur = '0;
        repeat (3) @(negedge clk);
        chk("reset bz",    32'(bz_a),   32'd0);
        chk("reset led",   32'(led_a),  32'h7);
        chk("reset ready", 32'(rdy_a),  32'd1);
        chk("reset busy",  32'(busy_a), 32'd0);
        chk("reset nogap busy", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        play(4'd10, 10'd3, 1'b0, 4'd0, -1, "code10 dur3");
        play(4'd0,  10'd2, 1'b0, 4'd0, -1, "rest0 dur2");
        play(4'd14, 10'd1, 1'b0, 4'd0, -1, "rest14");
        play(4'd15, 10'd1, 1'b0, 4'd0, -1, "rest15");

        // zero duration: accepted, nothing plays
        vld = 1'b1; code = 4'd5; dur = 10'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dur0 ready", 32'(rdy_a),  32'd1);
            chk("dur0 busy",  32'(busy_a), 32'd0);
            chk("dur0 bz",    32'(bz_a),   32'd0);
        end
        chk("dur0 led", 32'(led_a), 32'h7);
        vld = 1'b0;
        @(negedge clk);

        play(4'd10, 10'd3, 1'b0, 4'd0, 120, "reset mid-tone");
        @(negedge clk);
        play(4'd13, 10'd1, 1'b0, 4'd0, -1, "after reset");

        for (int i = 0; i < 6; i++)
            play(4'($urandom_range(0, 15)), 10'($urandom_range(1, 4)), 1'b0, 4'd0, -1, "random");

        sel = 1'b1;
        @(negedge clk);
        play(4'd1, 10'd1, 1'b1, 4'd13, -1, "b2b first");
        t1 = hs_time;
        play(4'd13, 10'd1, 1'b0, 4'd0, -1, "b2b second");
        chk("b2b accept spacing", 32'((hs_time - t1) / 10), 32'(MS_CYC + 1));
        for (int i = 0; i < 3; i++)
            play(4'($urandom_range(0, 15)), 10'($urandom_range(1, 3)), 1'b0, 4'd0, -1, "nogap random");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
